cpu_run_ctrl: RTL and testbench

//  Run/step/breakpoint sequencer for cpuunit. Converts raw board switches into a
//  one-cycle clock-enable pulse (cpu_en) consumed by cpuunit. Supports free-run at
//  a divided rate, single-step on a button edge, and halt on PC breakpoint.

---
 rtl/cpu_run_ctrl.sv | 124 ++++++++++++
 tb/tb_cpu_run_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/breakpoint sequencer for cpuunit.
// Turns raw board switches into a single-cycle cpu_en pulse. The CPU can
// free-run at a divided rate, single-step on a button press, or halt when
// the PC hits a breakpoint.
module cpu_run_ctrl #(
  parameter int DIV        = 50_000_000,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  sw,
  input  logic [15:0] PC,
  input  logic [15:0] bp_addr,
  input  logic        bp_en,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic [15:0] steps
);

  localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [1:0] S_HALT  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_STEP  = 2'b10;
  localparam logic [1:0] S_BREAK = 2'b11;

  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    db_q, db_d;
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];
  logic          db_step_prev_q, db_step_prev_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    state_q, state_d;
  logic          cpu_en_q, cpu_en_d;
  logic [15:0]   steps_q, steps_d;

  logic db_run, step_req, tick, bp_hit;

  // Two-stage synchronizer followed by a per-bit stability counter.
  // A bit is accepted only after it has differed from the debounced value
  // for DEB_CYCLES consecutive cycles; any return to agreement clears it.
  always_comb begin
    sync1_d = sw;
    sync2_d = sync1_q;
    db_d    = db_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DW'(DEB_CYCLES - 1)) db_d[i] = sync2_q[i];
        else                                 cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign db_run         = db_q[0];
  assign step_req       = db_q[1] & ~db_step_prev_q;
  assign db_step_prev_d = db_q[1];
  assign tick           = (presc_q == PW'(DIV - 1));
  assign bp_hit         = bp_en && (PC == bp_addr);

  // Sequencer: next state, enable pulse, prescaler and pulse counter.
  // The prescaler is held at zero outside RUN, so every RUN entry starts a
  // fresh DIV-cycle period. cpu_en is registered alongside the state, which
  // lines the STEP pulse up exactly with state==STEP.
  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    case (state_q)
      S_HALT: begin
        if (db_run)        state_d = S_RUN;
        else if (step_req) state_d = S_STEP;
      end
      S_RUN: begin
        if (!db_run)              state_d = S_HALT;
        else if (tick && bp_hit)  state_d = S_BREAK;
        else if (tick)            cpu_en_d = 1'b1;
      end
      S_STEP: begin
        state_d = db_run ? S_RUN : S_HALT;
      end
      default: begin
        if (!db_run)       state_d = S_HALT;
        else if (step_req) state_d = S_STEP;
      end
    endcase
    if (state_d == S_STEP) cpu_en_d = 1'b1;
    presc_d = (state_q == S_RUN && !tick) ? presc_q + 1'b1 : '0;
    steps_d = steps_q + {15'd0, cpu_en_q};
  end

  // State registers; reset overrides every pending event.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      db_q           <= '0;
      cnt_q[0]       <= '0;
      cnt_q[1]       <= '0;
      db_step_prev_q <= 1'b0;
      presc_q        <= '0;
      state_q        <= S_HALT;
      cpu_en_q       <= 1'b0;
      steps_q        <= '0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      db_q           <= db_d;
      cnt_q[0]       <= cnt_d[0];
      cnt_q[1]       <= cnt_d[1];
      db_step_prev_q <= db_step_prev_d;
      presc_q        <= presc_d;
      state_q        <= state_d;
      cpu_en_q       <= cpu_en_d;
      steps_q        <= steps_d;
    end
  end

  assign cpu_en = cpu_en_q;
  assign state  = state_q;
  assign steps  = steps_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed bench for cpu_run_ctrl with DEB_CYCLES=4, DIV=8.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  sw;
  logic [15:0] pc;
  logic [15:0] bp_addr;
  logic        bp_en;
  logic        cpu_en;
  logic [1:0]  state;
  logic [15:0] steps;

  int   total;
  int   bad;
  int   pulses;
  logic prev_en;
  logic b2b;

  cpu_run_ctrl #(.DIV(8), .DEB_CYCLES(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .sw      (sw),
    .PC      (pc),
    .bp_addr (bp_addr),
    .bp_en   (bp_en),
    .cpu_en  (cpu_en),
    .state   (state),
    .steps   (steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n cycles, sampling on the falling edge. Each observed pulse is
  // counted and advances the PC model, as cpuunit would.
  task automatic step_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (cpu_en === 1'b1) begin
        if (prev_en === 1'b1) b2b = 1'b1;
        pulses++;
        pc = pc + 16'd1;
      end
      prev_en = cpu_en;
    end
  endtask

  task automatic wait_state(input logic [1:0] exp, input int max, input string tag);
    int n;
    n = 0;
    while (state !== exp && n < max) begin
      step_cyc(1);
      n++;
    end
    chk(tag, 32'(state), 32'(exp));
  endtask

  // Hold the step button ~10 cycles; expect one pulse coinciding with STEP,
  // then the given state on the following cycle.
  task automatic press_step(input logic [1:0] exp_after);
    logic       seen;
    logic [1:0] st;
    seen = 1'b0;
    st   = 2'b00;
    sw[1] = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      step_cyc(1);
      if (cpu_en === 1'b1) begin
        seen = 1'b1;
        st   = state;
      end
    end
    chk("step_pulse", 32'(seen), 32'd1);
    chk("step_state", 32'(st), 32'h2);
    step_cyc(1);
    chk("step_after", 32'(state), 32'(exp_after));
    step_cyc(1);
    sw[1] = 1'b0;
    step_cyc(12);
  endtask

  initial begin
    total = 0; bad = 0; pulses = 0; prev_en = 1'b0; b2b = 1'b0;
    reset = 1'b1; sw = 2'b00; pc = 16'd0; bp_addr = 16'd0; bp_en = 1'b0;

    // 1: reset for 3 cycles with switches wiggling underneath
    step_cyc(1);
    sw = 2'b11;
    step_cyc(1);
    sw = 2'b00;
    step_cyc(1);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_en", 32'(cpu_en), 32'h0);
    chk("rst_steps", 32'(steps), 32'h0);
    reset = 1'b0;
    pulses = 0;
    step_cyc(12);
    chk("rst_quiet", 32'(pulses), 32'd0);
    chk("rst_quiet_state", 32'(state), 32'h0);

    // 2: 3-cycle glitch is filtered; a 10-cycle press gives one step
    sw[1] = 1'b1;
    step_cyc(3);
    sw[1] = 1'b0;
    step_cyc(12);
    chk("glitch_pulses", 32'(pulses), 32'd0);
    chk("glitch_state", 32'(state), 32'h0);
    press_step(2'b00);
    chk("step1_pulses", 32'(pulses), 32'd1);
    chk("step1_steps", 32'(steps), 32'd1);

    // 3: free run, one pulse every 8 cycles. RUN entry is cycle 0; pulses
    // land on cycles 8,16,..,96 -> 12 within the next 100 cycles.
    sw[0] = 1'b1;
    wait_state(2'b01, 20, "run_enter");
    pulses = 0;
    step_cyc(100);
    chk("run_pulses", 32'(pulses), 32'd12);
    chk("run_steps", 32'(steps), 32'd13);
    // Release on cycle 100: db_run falls after 6 edges, HALT on cycle 107.
    // The tick at cycle 103 still sees db_run=1, so one more pulse (104).
    sw[0] = 1'b0;
    wait_state(2'b00, 7, "run_halt");
    chk("run_tail_steps", 32'(steps), 32'd14);
    pulses = 0;
    step_cyc(20);
    chk("halt_no_pulse", 32'(pulses), 32'd0);

    // 4: breakpoint at 3 with PC counting from 0
    pc = 16'd0; bp_addr = 16'h0003; bp_en = 1'b1; pulses = 0;
    sw[0] = 1'b1;
    wait_state(2'b11, 100, "bp_break");
    chk("bp_pulses", 32'(pulses), 32'd3);
    chk("bp_pc", 32'(pc), 32'h3);
    pulses = 0;
    step_cyc(20);
    chk("bp_hold_pulses", 32'(pulses), 32'd0);
    chk("bp_hold_state", 32'(state), 32'h3);
    press_step(2'b01);
    sw[0] = 1'b0;
    wait_state(2'b00, 20, "bp_halt");
    bp_en = 1'b0;

    // 5: counter wrap, starting from a preloaded value near the top
    force dut.steps_q = 16'hFFFE;
    step_cyc(1);
    release dut.steps_q;
    step_cyc(1);
    chk("wrap_preload", 32'(steps), 32'hFFFE);
    press_step(2'b00);
    chk("wrap_ffff", 32'(steps), 32'hFFFF);
    press_step(2'b00);
    chk("wrap_zero", 32'(steps), 32'h0000);

    // 6: reset lands in the STEP cycle
    sw[1] = 1'b1;
    for (int i = 0; i < 20 && cpu_en !== 1'b1; i++) step_cyc(1);
    chk("rst_step_seen", 32'(state), 32'h2);
    reset = 1'b1;
    step_cyc(1);
    chk("rst_step_en", 32'(cpu_en), 32'h0);
    chk("rst_step_state", 32'(state), 32'h0);
    chk("rst_step_steps", 32'(steps), 32'h0);
    sw[1] = 1'b0;
    step_cyc(2);
    reset = 1'b0;
    pulses = 0;
    step_cyc(15);
    chk("rst_step_quiet", 32'(pulses), 32'd0);
    chk("no_b2b", 32'(b2b), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
